// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: blanking
// constants, the update payload record and the hex glyph table.
package seg_pkg;

    // All segments off (active-low) and all anodes off (active-low).
    localparam logic [0:6] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // One complete display update: four hex digits plus per-digit decimal
    // point, per-digit enable and a global brightness level.
    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  mask;
        logic [3:0]  brightness;
    } seg_payload_t;

    // Glyphs for 0..F, segments a..g in index order 0..6, active-low.
    localparam logic [0:6] HEX_SEG_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/hex_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
// Shared by every display block that drives the Basys3 segment pins.
module hex_seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [0:6] o_seg
);

    assign o_seg = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit common-anode scan controller: free-running digit/slot
// counter, frame-aligned update handshake, ghosting guard, brightness PWM
// and leading-zero blanking, with registered anode/segment outputs.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int DWELL_BITS = 17,
    parameter bit LZB        = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    input  logic [3:0]  upd_dp,
    input  logic [3:0]  upd_mask,
    input  logic [3:0]  upd_brightness,
    output logic        upd_ready,
    output logic        frame_start,
    output logic [3:0]  an,
    output logic [0:6]  seg,
    output logic        dp
);

    localparam int CNT_W = DWELL_BITS + 2;

    // Scan state and update buffering
    logic [CNT_W-1:0] r_cnt;
    logic             r_pending;
    seg_payload_t     r_pend_data;
    seg_payload_t     r_disp;

    // Registered pin drivers
    logic [3:0]       r_an;
    logic [0:6]       r_seg;
    logic             r_dp;
    logic             r_frame_start;

    // Decoded scan position and per-cycle lighting decision
    logic [1:0]       w_digit;
    logic [3:0]       w_phase;
    logic             w_wrap;
    logic             w_accept;
    logic [3:0]       w_nibble;
    logic [0:6]       w_dec_seg;
    logic [3:0]       w_lzb_blank;
    logic [3:0]       w_blank;
    logic             w_lit;
    seg_payload_t     w_upd_payload;

    assign w_digit  = r_cnt[CNT_W-1 -: 2];
    assign w_phase  = r_cnt[DWELL_BITS-1 -: 4];
    assign w_wrap   = &r_cnt;
    assign w_accept = upd_valid & ~r_pending;
    assign w_nibble = r_disp.data[{w_digit, 2'b00} +: 4];

    assign w_upd_payload = '{data: upd_data, dp: upd_dp,
                             mask: upd_mask, brightness: upd_brightness};

    assign upd_ready   = ~r_pending;
    assign frame_start = r_frame_start;
    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;

    hex_seg_decoder u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    // Blanking: masked digits, plus digits above the most significant
    // nonzero nibble when leading-zero blanking is on (digit 0 always shows).
    always_comb begin
        w_lzb_blank    = 4'b0000;
        w_lzb_blank[1] = (r_disp.data[15:4]  == 12'h000);
        w_lzb_blank[2] = (r_disp.data[15:8]  == 8'h00);
        w_lzb_blank[3] = (r_disp.data[15:12] == 4'h0);
        w_blank        = ~r_disp.mask | (LZB ? w_lzb_blank : 4'b0000);
        // Phase 0 is the inter-digit guard; brightness sets the last lit phase.
        w_lit = (w_phase != 4'd0) && (w_phase <= r_disp.brightness)
                && !w_blank[w_digit];
    end

    // Free-running {digit, slot} counter; wraps every frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Pending flag and display register: a held update is committed only on
    // the wrap cycle so a frame never mixes old and new values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_disp    <= '0;
        end else if (w_wrap && r_pending) begin
            r_disp    <= r_pend_data;
            r_pending <= 1'b0;
        end else if (w_accept) begin
            r_pending <= 1'b1;
        end
    end

    // Capture the offered payload on acceptance; the flag alone tracks validity.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pend_data <= w_upd_payload;
        end
    end

    // Output registers: one cycle behind the counter, blanked when no anode is on.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an          <= AN_OFF;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= (r_cnt == '0);
            if (w_lit) begin
                r_an  <= ~(4'b0001 << w_digit);
                r_seg <= w_dec_seg;
                r_dp  <= ~r_disp.dp[w_digit];
            end else begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
                r_dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller with a 16-cycle slot (64-cycle frame).
// A cycle model pushes expected outputs at each rising edge; a checker
// pops and compares them on the falling edge. Directed steps add
// frame-level checks for each scenario.
module tb_seg_scan_controller;

    localparam int DW = 4;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  mask;
        logic [3:0]  bright;
    } tb_pl_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data = '0;
    logic [3:0]  upd_dp = '0;
    logic [3:0]  upd_mask = '0;
    logic [3:0]  upd_brightness = '0;

    logic        upd_ready, frame_start, dp;
    logic [3:0]  an;
    logic [0:6]  seg;
    logic        upd_ready2, frame_start2, dp2;
    logic [3:0]  an2;
    logic [0:6]  seg2;

    int n_checks = 0;
    int n_errors = 0;

    exp_t   exp_q[$];
    logic [5:0] m_cnt;
    logic   m_pend;
    tb_pl_t m_disp, m_pbuf;

    always #5 clk = ~clk;

    seg_scan_controller #(.DWELL_BITS(DW), .LZB(1'b1)) u_dut (
        .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_data(upd_data),
        .upd_dp(upd_dp), .upd_mask(upd_mask), .upd_brightness(upd_brightness),
        .upd_ready(upd_ready), .frame_start(frame_start), .an(an), .seg(seg), .dp(dp)
    );

    seg_scan_controller #(.DWELL_BITS(DW), .LZB(1'b0)) u_dut_nolzb (
        .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_data(upd_data),
        .upd_dp(upd_dp), .upd_mask(upd_mask), .upd_brightness(upd_brightness),
        .upd_ready(upd_ready2), .frame_start(frame_start2), .an(an2), .seg(seg2), .dp(dp2)
    );

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b0000001;
            4'h1: glyph = 7'b1001111;
            4'h2: glyph = 7'b0010010;
            4'h3: glyph = 7'b0000110;
            4'h4: glyph = 7'b1001100;
            4'h5: glyph = 7'b0100100;
            4'h6: glyph = 7'b0100000;
            4'h7: glyph = 7'b0001111;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0000100;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b1100000;
            4'hC: glyph = 7'b0110001;
            4'hD: glyph = 7'b1000010;
            4'hE: glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference model: expected registered outputs from the pre-edge state.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt  = '0;
            m_pend = 1'b0;
            m_disp = '0;
            exp_q.delete();
        end else begin : model_step
            exp_t       e;
            logic [1:0] d;
            logic [3:0] ph;
            logic [3:0] nib;
            int         msd;
            logic       blank, lit, acc;
            d   = m_cnt[5:4];
            ph  = m_cnt[3:0];
            msd = 0;
            for (int i = 1; i < 4; i++)
                if (m_disp.data[i*4 +: 4] != 4'h0) msd = i;
            blank = !m_disp.mask[d] || (int'(d) > msd);
            lit   = (ph >= 4'd1) && (ph <= m_disp.bright) && !blank;
            nib   = m_disp.data[{d, 2'b00} +: 4];
            e.an  = lit ? ~(4'b0001 << d) : 4'b1111;
            e.seg = lit ? glyph(nib) : 7'b1111111;
            e.dp  = lit ? ~m_disp.dp[d] : 1'b1;
            e.fs  = (m_cnt == 6'd0);
            exp_q.push_back(e);
            acc = upd_valid && !m_pend;
            if (m_cnt == 6'h3F && m_pend) begin
                m_disp = m_pbuf;
                m_pend = 1'b0;
            end
            if (acc) begin
                m_pbuf = '{data: upd_data, dp: upd_dp, mask: upd_mask, bright: upd_brightness};
                m_pend = 1'b1;
            end
            m_cnt = m_cnt + 6'd1;
        end
    end

    // Scoreboard checker on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dp", 32'(dp), 32'h1);
            chk("rst_ready", 32'(upd_ready), 32'h1);
        end else if (exp_q.size() != 0) begin : pop_cmp
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_an", 32'(an), 32'(e.an));
            chk("sb_seg", 32'(seg), 32'(e.seg));
            chk("sb_dp", 32'(dp), 32'(e.dp));
            chk("sb_fs", 32'(frame_start), 32'(e.fs));
            chk("sb_ready", 32'(upd_ready), 32'(!m_pend));
        end
    end

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] p,
                         input logic [3:0] m, input logic [3:0] b);
        upd_valid = v; upd_data = d; upd_dp = p; upd_mask = m; upd_brightness = b;
    endtask

    // Advance to the next falling edge showing frame_start (bounded).
    task automatic wait_fs();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (frame_start) break;
        end
        if (k == 200) chk("fs_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_cnt(input logic [5:0] target);
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_cnt == target) break;
        end
        if (k == 200) chk("cnt_timeout", 32'd0, 32'd1);
    endtask

    initial begin : stim
        int lit_n, lit2_n, dpl_n, dpx_n, k;
        logic [3:0] an_exp [4];
        logic [6:0] seg_exp [4];
        an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_exp = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};

        // 1. Reset held three cycles, then a dark frame.
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("first_fs", 32'(frame_start), 32'd1);
        lit_n = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            if (an != 4'hF) lit_n++;
        end
        chk("dark_frame_lit", 32'(lit_n), 32'd0);

        // 2. Basic scan of 0x1234 at full brightness.
        #2 drive(1'b1, 16'h1234, 4'b0000, 4'b1111, 4'd15);
        @(negedge clk);
        #2 drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        wait_fs();
        lit_n = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            if (an != 4'hF) lit_n++;
            if (i % 16 == 0) chk("guard_an", 32'(an), 32'hF);
            if (i % 16 == 1) begin
                chk("scan_an", 32'(an), 32'(an_exp[i/16]));
                chk("scan_seg", 32'(seg), 32'(seg_exp[i/16]));
            end
        end
        chk("full_bright_lit", 32'(lit_n), 32'd60);

        // 3. Brightness 3 with leading-zero blanking on and off.
        #2 drive(1'b1, 16'h0005, 4'b0000, 4'b1111, 4'd3);
        @(negedge clk);
        #2 drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        wait_fs();
        lit_n = 0; lit2_n = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            if (an != 4'hF) lit_n++;
            if (an2 != 4'hF) lit2_n++;
            if (i == 1) chk("lzb_seg5", 32'(seg), 32'(7'b0100100));
            if (i == 49) begin
                chk("nolzb_an3", 32'(an2), 32'(4'b0111));
                chk("nolzb_seg0", 32'(seg2), 32'(7'b0000001));
            end
        end
        chk("lzb_lit", 32'(lit_n), 32'd3);
        chk("nolzb_lit", 32'(lit2_n), 32'd12);

        // 4. Backpressure: A mid-frame, then B held until ready returns.
        wait_cnt(6'd20);
        #2 drive(1'b1, 16'h00AB, 4'b0000, 4'b1111, 4'd15);
        @(negedge clk);
        chk("bp_ready_low", 32'(upd_ready), 32'd0);
        #2 drive(1'b1, 16'h00CD, 4'b0000, 4'b1111, 4'd15);
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (upd_ready) break;
        end
        chk("bp_ready_rise", 32'(upd_ready), 32'd1);
        @(negedge clk);
        chk("bp_fs_A", 32'(frame_start), 32'd1);
        chk("bp_B_taken", 32'(upd_ready), 32'd0);
        #2 drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        chk("bp_A_shown", 32'(seg), 32'(7'b1100000));
        wait_fs();
        @(negedge clk);
        chk("bp_B_shown", 32'(seg), 32'(7'b1000010));

        // 5. Update offered on the wrap cycle, with decimal point on digit 2.
        wait_cnt(6'h3F);
        #2 drive(1'b1, 16'h4321, 4'b0100, 4'b1111, 4'd15);
        @(negedge clk);
        #2 drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        chk("wrap_acc_ready", 32'(upd_ready), 32'd0);
        wait_fs();
        dpl_n = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            if (dp == 1'b0) dpl_n++;
        end
        chk("wrap_not_applied", 32'(dpl_n), 32'd0);
        wait_fs();
        dpl_n = 0; dpx_n = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            if (dp == 1'b0) dpl_n++;
            if (dp == 1'b0 && an != 4'b1011) dpx_n++;
        end
        chk("dp_lit_count", 32'(dpl_n), 32'd15);
        chk("dp_other_digits", 32'(dpx_n), 32'd0);

        // 6. Reset while an update is pending, mid-slot.
        wait_cnt(6'd6);
        #2 drive(1'b1, 16'h8888, 4'b1111, 4'b1111, 4'd15);
        @(negedge clk);
        #2 drive(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
        chk("mid_pending", 32'(upd_ready), 32'd0);
        chk("mid_lit_before", 32'(an), 32'(4'b1110));
        #1 reset = 1'b1;
        #1;
        chk("async_an", 32'(an), 32'hF);
        chk("async_seg", 32'(seg), 32'h7F);
        chk("async_dp", 32'(dp), 32'd1);
        chk("async_fs", 32'(frame_start), 32'd0);
        chk("async_ready", 32'(upd_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("rel_fs", 32'(frame_start), 32'd1);
        chk("rel_ready", 32'(upd_ready), 32'd1);
        lit_n = 0;
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (an != 4'hF) lit_n++;
        end
        chk("pending_discarded", 32'(lit_n), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexed scan controller for the Basys3 four-digit common-anode seven-segment display. It owns the digit-select counter, anode sequencing, inter-digit ghosting guard, brightness PWM and leading-zero blanking. A 16-bit hex value arrives through a valid/ready update port. It is applied only at frame boundaries, so the display never tears. The block sits between any value-producing logic (switches, counters) and the board pins `an`, `seg` and `dp`. It instantiates the shared hex-to-segment decoder.

## Interface
- `DWELL_BITS`, default 17: width of the per-digit slot counter. Slot length is 2^DWELL_BITS cycles. Must be ≥ 4.
- `LZB`, default 1: 1 enables leading-zero blanking; 0 disables it.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `upd_valid` input 1: an update is offered.
- `upd_data` input 16: four hex digits. Digit 0 is bits [3:0] and is the rightmost digit.
- `upd_dp` input 4: per-digit decimal point, 1 = lit.
- `upd_mask` input 4: per-digit enable, 1 = digit may light.
- `upd_brightness` input 4: 0 = dark, 15 = maximum.
- `upd_ready` output 1: an update can be accepted.
- `frame_start` output 1: one-cycle pulse marking the first output cycle of digit 0.
- `an` output 4: anodes, active-low. `an[i]` selects digit i.
- `seg` output [0:6]: segments a..g, active-low.
- `dp` output 1: decimal point, active-low.

## Operation
- **Scan counter.**
  - `{digit[1:0], slot[DWELL_BITS-1:0]}` increments every cycle and wraps freely.
  - Digit order is 0,1,2,3,0,…
  - One frame is 4·2^DWELL_BITS cycles.
- **Phase.** Phase = `slot[DWELL_BITS-1 -: 4]`, giving 16 phases per slot.
- **Anode enable.** Digit i's anode is driven low only when all of the following hold:
  - phase ≥ 1 (phase 0 is the ghosting guard; all anodes are off);
  - phase ≤ displayed brightness;
  - digit i is not blanked.
  - Brightness 0 therefore keeps all anodes off. Brightness 15 lights 15/16 of each slot.
- **Blanking.**
  - A digit is blanked if its `mask` bit is 0.
  - With LZB=1, a digit is also blanked if it lies above the most significant nonzero digit. Digit 0 is never LZB-blanked, so value 0x0000 shows "0".
  - A blanked digit keeps its anode high for the entire slot.
- **Segment outputs.**
  - `seg` = decoded nibble of the current digit; `dp` = ~`dp` bit of the current digit.
  - Both are forced to all-ones whenever no anode is low.
- **Display register.** Holds data, dp, mask and brightness. The scan logic reads only this register.
- **Update handshake.**
  - `upd_ready` = ~pending.
  - Transfer occurs when `upd_valid` && `upd_ready`. The payload goes into a pending register and pending is set.
  - At the wrap cycle (counter all-ones → 0), if pending: display register ← pending register, and pending clears.
  - `upd_valid` while pending is ignored; there is no overwrite.
  - An update accepted on the wrap cycle itself is applied at the next wrap.
- **Reset values.**
  - Counter 0, pending 0, `upd_ready` 1.
  - Display register: data 0, dp 0, mask 0, brightness 0.
  - `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1, `frame_start` = 0.
- **Reset mid-frame.** Outputs blank asynchronously. Any pending update is discarded.

## Timing
- `an`, `seg`, `dp` and `frame_start` are registered: each reflects the counter value of the previous cycle (1-cycle latency).
- `frame_start` is high in the cycle after the counter equals 0.
- The first `frame_start` occurs 1 cycle after reset deasserts.
- An update accepted at cycle t becomes visible on the first `frame_start` after the next wrap.
- With DWELL_BITS=4, phase equals `slot` (1 cycle per phase), a slot is 16 cycles and a frame is 64 cycles.
- `upd_ready` falls in the cycle after acceptance. It rises in the cycle after the applying wrap.

## Structure
- **Shared package `seg_pkg`** holds:
  - `SEG_BLANK` = 7'b1111111 and `AN_OFF` = 4'b1111;
  - the `seg_payload_t` struct (data, dp, mask, brightness);
  - the 16-entry hex-to-segment constant table.
- **Sub-module `hex_seg_decoder`** is the combinational nibble → [0:6] active-low decoder. It is reused by other display blocks.
- The top level contains the counter, the handshake/pending logic, blank/LZB evaluation and the output registers.

## Test plan
All scenarios use DWELL_BITS=4.

1. **Reset.** Hold `reset` for 3 cycles, with `upd_valid` held low throughout.
   - During reset: `an` = 1111, `seg` = 1111111, `dp` = 1, `upd_ready` = 1.
   - After release: `an` stays 1111 for a full frame, because mask and brightness are 0.
2. **Basic scan.**
   - Stimulus: update data = 0x1234, mask = 1111, dp = 0000, brightness = 15.
   - After the next wrap, in digit 0's slot: `an` = 1110 for output phases 1..15 with `seg` = "4" (7'b1001100). Phase 0 shows `an` = 1111.
   - Digits 1, 2 and 3 follow with `an` = 1101/1011/0111 and segments "3", "2", "1".
3. **Brightness and leading-zero blanking.**
   - Stimulus: data = 0x0005, brightness = 3, LZB = 1.
   - Only digit 0 lights, for phases 1..3 (3 cycles per 64-cycle frame).
   - With LZB=0, all four digits light and digits 1..3 show "0".
4. **Handshake backpressure.**
   - Stimulus: offer A mid-frame, then hold `upd_valid` with payload B.
   - `upd_ready` stays 0 until the wrap. A is displayed. B is accepted in the cycle after `upd_ready` rises and is displayed one frame later; B is never merged with A.
5. **Wrap-cycle acceptance and decimal point.**
   - Stimulus: offer an update exactly on the wrap cycle, with `upd_dp` = 0100.
   - The update is not displayed in the frame that starts immediately; it is applied at the following wrap.
   - Once applied, `dp` = 0 only during digit 2's lit phases.
6. **Reset mid-update.**
   - Stimulus: assert `reset` while pending = 1 and mid-slot.
   - Outputs blank within the same cycle. After release, the pending update is discarded: the display register holds its reset values and `upd_ready` = 1.
